// File: rtl/taiga_types.sv
// Shared types and helpers for the RAS controller.
package taiga_types;

    // What an instruction does to the return address stack
    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_POP_PUSH
    } ras_op_t;

    localparam logic [6:0] JAL_OP  = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111;

    // One in-flight predicted return: target, plus a flag for "RAS was empty"
    typedef struct packed {
        logic        no_pred;
        logic [31:0] target;
    } ret_entry_t;

    // RISC-V link-register hint: x1 (ra) or x5 (t0)
    function automatic logic link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/ras_return_fifo.sv
// Queue of predicted returns awaiting resolution, read head combinationally.
module ras_return_fifo
    import taiga_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  ret_entry_t                 wr_data,
    input  logic                       rd_en,
    output ret_entry_t                 rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    ret_entry_t          mem_reg [DEPTH];
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [AW:0]         count_reg;
    logic                full;
    logic                do_wr;
    logic                do_rd;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_wr   = wr_en & !full;
    assign do_rd   = rd_en & !empty;
    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    // Storage: contents need no reset, only pointers do
    always_ff @(posedge clk) begin
        if (do_wr)
            mem_reg[wr_ptr_reg] <= wr_data;
    end

    // Pointer and occupancy bookkeeping; flush empties the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_wr && !do_rd)
                count_reg <= count_reg + 1'b1;
            else if (!do_wr && do_rd)
                count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// Fetch-side RAS controller: classifies calls/returns, drives the RAS,
// predicts return targets and tracks prediction accuracy.
module ras_ctrl
    import taiga_types::*;
#(
    parameter int RETURN_FIFO_DEPTH = 4,
    parameter int COUNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [31:0]        fetch_pc,
    input  logic [31:0]        fetch_instr,
    input  logic               fetch_flush,
    input  logic               pipeline_flush,
    output logic               ras_push,
    output logic               ras_pop,
    output logic [31:0]        ras_new_addr,
    input  logic [31:0]        ras_addr,
    input  logic               ras_valid,
    output logic               predict_valid,
    output logic [31:0]        predict_target,
    input  logic               resolve_valid,
    input  logic [31:0]        resolve_target,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic               resolve_underflow
);
    localparam int AW = $clog2(RETURN_FIFO_DEPTH);

    logic               dec_valid_reg;
    logic [31:0]        dec_pc_reg;
    ras_op_t            dec_op_reg;
    logic [COUNT_W-1:0] hit_count_reg;
    logic [COUNT_W-1:0] miss_count_reg;
    logic               underflow_reg;

    logic               accept;
    logic               live;
    logic               dec_is_ret;
    logic               q_write;
    logic               q_read;
    logic               q_empty;
    logic [AW:0]        q_count;
    logic [AW+1:0]      pending;
    ret_entry_t         q_wr_data;
    ret_entry_t         q_head;
    logic [11:0]        unused_instr_hi;

    assign unused_instr_hi = fetch_instr[31:20];

    // Decode the low 20 bits of an instruction into a RAS operation
    function automatic ras_op_t classify(input logic [19:0] instr);
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [4:0] rs1;
        op  = instr[6:0];
        rd  = instr[11:7];
        f3  = instr[14:12];
        rs1 = instr[19:15];
        classify = RAS_NONE;
        if (op == JAL_OP) begin
            if (link_reg(rd))
                classify = RAS_PUSH;
        end else if (op == JALR_OP && f3 == 3'b000) begin
            if (link_reg(rd) && !link_reg(rs1))
                classify = RAS_PUSH;
            else if (!link_reg(rd) && link_reg(rs1))
                classify = RAS_POP;
            else if (link_reg(rd) && link_reg(rs1))
                classify = (rd != rs1) ? RAS_POP_PUSH : RAS_PUSH;
        end
    endfunction

    assign accept     = fetch_valid & fetch_ready;
    assign dec_is_ret = (dec_op_reg == RAS_POP) || (dec_op_reg == RAS_POP_PUSH);
    assign live       = dec_valid_reg & !fetch_flush & !pipeline_flush;

    // Conservative: counts the return sitting in decode, ignores same-cycle resolve
    assign pending     = {1'b0, q_count} + {{(AW+1){1'b0}}, dec_valid_reg & dec_is_ret};
    assign fetch_ready = pending < (AW+2)'(RETURN_FIFO_DEPTH);

    assign ras_push       = live & ((dec_op_reg == RAS_PUSH) || (dec_op_reg == RAS_POP_PUSH));
    assign ras_pop        = live & dec_is_ret;
    assign ras_new_addr   = dec_pc_reg + 32'd4;
    assign predict_valid  = live & dec_is_ret & ras_valid;
    assign predict_target = ras_addr;

    assign q_write           = live & dec_is_ret;
    assign q_wr_data.no_pred = !ras_valid;
    assign q_wr_data.target  = ras_addr;
    assign q_read            = resolve_valid & !pipeline_flush & !q_empty;

    assign hit_count         = hit_count_reg;
    assign miss_count        = miss_count_reg;
    assign resolve_underflow = underflow_reg;

    ras_return_fifo #(
        .DEPTH (RETURN_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (pipeline_flush),
        .wr_en   (q_write),
        .wr_data (q_wr_data),
        .rd_en   (q_read),
        .rd_data (q_head),
        .count   (q_count),
        .empty   (q_empty)
    );

    // Decode register: holds the accepted instruction for one cycle
    always_ff @(posedge clk) begin
        if (rst || pipeline_flush) begin
            dec_valid_reg <= 1'b0;
        end else begin
            dec_valid_reg <= accept;
        end
        if (accept) begin
            dec_pc_reg <= fetch_pc;
            dec_op_reg <= classify(fetch_instr[19:0]);
        end
    end

    // Prediction statistics and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
            underflow_reg  <= 1'b0;
        end else if (!pipeline_flush && resolve_valid) begin
            if (q_empty) begin
                underflow_reg <= 1'b1;
            end else if (!q_head.no_pred && q_head.target == resolve_target) begin
                if (hit_count_reg != '1)
                    hit_count_reg <= hit_count_reg + 1'b1;
            end else begin
                if (miss_count_reg != '1)
                    miss_count_reg <= miss_count_reg + 1'b1;
            end
        end
    end

endmodule
